// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcodes, ALU op classes, field positions, control bundle.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package mips_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  // Instruction field bit positions
  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_SLTI  = 6'h0A;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_FUNCT = 3'd2,
    ALU_AND   = 3'd3,
    ALU_OR    = 3'd4,
    ALU_SLT   = 3'd5
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    alu_src;
    logic    reg_dst;
    logic    branch;
    alu_op_e alu_op;
    logic    illegal;
  } ctrl_t;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs_data;
    logic [XLEN-1:0]   rt_data;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [5:0]        funct;
    ctrl_t             ctrl;
  } idex_t;

  function automatic ctrl_t decode_ctrl(input logic [5:0] opc);
    ctrl_t c;
    c = '0;
    case (opc)
      OP_RTYPE: begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.alu_op = ALU_FUNCT; end
      OP_LW:    begin c.reg_write = 1'b1; c.mem_read = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_ADD; end
      OP_SW:    begin c.mem_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_ADD; end
      OP_BEQ:   begin c.branch = 1'b1; c.alu_op = ALU_SUB; end
      OP_ADDI:  begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_ADD; end
      OP_ANDI:  begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_AND; end
      OP_ORI:   begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_OR; end
      OP_SLTI:  begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_SLT; end
      default:  c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  // Opcodes whose rt is a source operand (not just a destination)
  function automatic logic reads_rt(input logic [5:0] opc);
    return (opc == OP_RTYPE) || (opc == OP_SW) || (opc == OP_BEQ);
  endfunction

endpackage

// File: rtl/instruction_decode_if.sv
// Bundle between fetch/write-back/execute and the decode stage.
// Latency: none (wiring only).
// Backpressure: stall from decode holds fetch.
// Ports: master = environment (drives instr, pc, wb, ex hazard info; sees stall and ID/EX);
//        slave  = decode stage.
interface instruction_decode_if;
  import mips_pkg::*;

  logic [XLEN-1:0]   instr;
  logic [XLEN-1:0]   pc_in;
  logic              load_mem_en;
  logic              wb_en;
  logic [REG_AW-1:0] wb_addr;
  logic [XLEN-1:0]   wb_data;
  logic              ex_mem_read;
  logic [REG_AW-1:0] ex_rt;

  logic              stall;
  logic              id_valid;
  logic [XLEN-1:0]   id_pc;
  logic [XLEN-1:0]   id_rs_data;
  logic [XLEN-1:0]   id_rt_data;
  logic [XLEN-1:0]   id_imm;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic [5:0]        id_funct;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_mem_write;
  logic              id_alu_src;
  logic              id_reg_dst;
  logic              id_branch;
  logic [2:0]        id_alu_op;
  logic              id_illegal;

  modport master (
    output instr, pc_in, load_mem_en, wb_en, wb_addr, wb_data, ex_mem_read, ex_rt,
    input  stall, id_valid, id_pc, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
           id_funct, id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_reg_dst,
           id_branch, id_alu_op, id_illegal
  );

  modport slave (
    input  instr, pc_in, load_mem_en, wb_en, wb_addr, wb_data, ex_mem_read, ex_rt,
    output stall, id_valid, id_pc, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
           id_funct, id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_reg_dst,
           id_branch, id_alu_op, id_illegal
  );
endinterface

// File: rtl/instruction_decode_register_file.sv
// 2-read/1-write register file, r0 hardwired to zero, same-cycle write-back bypass.
// Latency: reads combinational, write lands on the rising edge.
// Backpressure: none.
// Ports: clk/rst_n; rs/rt read addresses and data; wb_en/wb_addr/wb_data write port.
module register_file #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     rs_addr_i,
  input  logic [AW-1:0]     rt_addr_i,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  input  logic              wb_en_i,
  input  logic [AW-1:0]     wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              wr_ok;

  assign wr_ok = wb_en_i && (wb_addr_i != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[wb_addr_i] <= wb_data_i;
    end
  end

  // A write in flight this cycle is visible to the reader immediately; r0 is never
  // written so it always reads zero.
  assign rs_data_o = (wr_ok && wb_addr_i == rs_addr_i) ? wb_data_i : regs_q[rs_addr_i];
  assign rt_data_o = (wr_ok && wb_addr_i == rt_addr_i) ? wb_data_i : regs_q[rt_addr_i];

endmodule

// File: rtl/instruction_decode.sv
// MIPS decode stage: IF/ID register, field/control decode, register read, ID/EX register.
// Latency: instruction captured at edge N appears on id_* after edge N+1.
// Backpressure: combinational stall on load-use; IF/ID holds and ID/EX takes a bubble.
// Ports: clk, rst_n (async active-low); bus (slave) carries fetch, write-back,
//        execute hazard inputs and the stall / ID/EX outputs.
module instruction_decode
  import mips_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  instruction_decode_if.slave bus
);

  logic            ifid_vld_q;
  logic [XLEN-1:0] ifid_instr_q;
  logic [XLEN-1:0] ifid_pc_q;

  logic [5:0]        opc;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [5:0]        funct;
  logic [15:0]       imm16;
  logic [XLEN-1:0]   rs_data, rt_data;
  logic              stall;
  idex_t             idex_d, idex_q;

  assign opc   = ifid_instr_q[OPC_HI:OPC_LO];
  assign rs    = ifid_instr_q[RS_HI:RS_LO];
  assign rt    = ifid_instr_q[RT_HI:RT_LO];
  assign rd    = ifid_instr_q[RD_HI:RD_LO];
  assign funct = ifid_instr_q[FUNCT_HI:FUNCT_LO];
  assign imm16 = ifid_instr_q[IMM_HI:IMM_LO];

  register_file #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W)
  ) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs_addr_i (rs),
    .rt_addr_i (rt),
    .rs_data_o (rs_data),
    .rt_data_o (rt_data),
    .wb_en_i   (bus.wb_en),
    .wb_addr_i (bus.wb_addr),
    .wb_data_i (bus.wb_data)
  );

  // Load-use hazard. rt only counts where it is a source; a load into r0 never hazards.
  // IF/ID valid is cleared asynchronously, so stall drops as soon as reset asserts.
  assign stall = ifid_vld_q && bus.ex_mem_read && (bus.ex_rt != '0) &&
                 ((bus.ex_rt == rs) || ((bus.ex_rt == rt) && reads_rt(opc)));
  assign bus.stall = stall;

  // IF/ID: a memory load-in bubbles even over a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_vld_q   <= 1'b0;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
    end else if (bus.load_mem_en) begin
      ifid_vld_q <= 1'b0;
    end else if (!stall) begin
      ifid_vld_q   <= 1'b1;
      ifid_instr_q <= bus.instr;
      ifid_pc_q    <= bus.pc_in;
    end
  end

  // Bubbles (stall or empty IF/ID) are driven as all-zero bundles.
  always_comb begin
    idex_d = '0;
    if (ifid_vld_q && !stall) begin
      idex_d.valid   = 1'b1;
      idex_d.pc      = ifid_pc_q;
      idex_d.rs_data = rs_data;
      idex_d.rt_data = rt_data;
      idex_d.imm     = (opc == OP_ANDI || opc == OP_ORI) ? {16'h0000, imm16}
                                                         : {{16{imm16[15]}}, imm16};
      idex_d.rs      = rs;
      idex_d.rt      = rt;
      idex_d.rd      = rd;
      idex_d.funct   = funct;
      idex_d.ctrl    = decode_ctrl(opc);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idex_q <= '0;
    else        idex_q <= idex_d;
  end

  assign bus.id_valid     = idex_q.valid;
  assign bus.id_pc        = idex_q.pc;
  assign bus.id_rs_data   = idex_q.rs_data;
  assign bus.id_rt_data   = idex_q.rt_data;
  assign bus.id_imm       = idex_q.imm;
  assign bus.id_rs        = idex_q.rs;
  assign bus.id_rt        = idex_q.rt;
  assign bus.id_rd        = idex_q.rd;
  assign bus.id_funct     = idex_q.funct;
  assign bus.id_reg_write = idex_q.ctrl.reg_write;
  assign bus.id_mem_read  = idex_q.ctrl.mem_read;
  assign bus.id_mem_write = idex_q.ctrl.mem_write;
  assign bus.id_alu_src   = idex_q.ctrl.alu_src;
  assign bus.id_reg_dst   = idex_q.ctrl.reg_dst;
  assign bus.id_branch    = idex_q.ctrl.branch;
  assign bus.id_alu_op    = idex_q.ctrl.alu_op;
  assign bus.id_illegal   = idex_q.ctrl.illegal;

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
- Pipeline stage directly downstream of instruction fetch.
- Latches the fetched `instr`/`pc_out` into an IF/ID register, decodes the MIPS fields and control, reads a 32x32 register file with write-back bypass, and registers everything into an ID/EX bundle for execute.
- Detects load-use hazards and drives `stall` back to fetch.

Parameters:
- NUM_REGS, 32, register file depth; rs/rt/rd are log2(NUM_REGS) = 5 bits.
- DATA_W, 32, datapath width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  32  instruction from fetch, combinational for the current pc.
- pc_in  in  32  fetch pc (word index, increments by 1).
- load_mem_en  in  1  fetch memory being loaded; suppresses capture.
- wb_en  in  1  write-back enable.
- wb_addr  in  5  write-back register.
- wb_data  in  32  write-back data.
- ex_mem_read  in  1  instruction currently in EX is a load.
- ex_rt  in  5  destination of that load.
- stall  out  1  hold fetch pc and IF/ID (combinational).
- id_valid  out  1  ID/EX bundle holds a real instruction.
- id_pc  out  32  pc of the instruction.
- id_rs_data  out  32  rs operand.
- id_rt_data  out  32  rt operand.
- id_imm  out  32  extended immediate.
- id_rs, id_rt, id_rd  out  5 each  register specifiers.
- id_funct  out  6  R-type funct.
- id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_reg_dst, id_branch  out  1 each  control.
- id_alu_op  out  3  ALU op class.
- id_illegal  out  1  unknown opcode.

Behaviour:
- Reset (async): IF/ID valid=0, all ID/EX outputs 0, all registers 0. `stall`=0 while in reset.
- IF/ID capture, each rising edge:
  - load_mem_en=1 → IF/ID valid<=0 (bubble).
  - else stall=1 → IF/ID holds.
  - else IF/ID <= {instr, pc_in}, valid<=1.
- Latency: an instruction presented with pc_in at edge N appears on id_* after edge N+1 (two edges total).
- Fields:
  - opcode = [31:26], rs = [25:21], rt = [20:16], rd = [15:11], funct = [5:0].
  - imm sign-extended from [15:0] except andi/ori, which are zero-extended.
- Decode table (reg_write, mem_read, mem_write, alu_src, reg_dst, branch, alu_op):
  - 0x00 R-type: 1 0 0 0 1 0 op=2 (funct decides).
  - 0x23 lw: 1 1 0 1 0 0 op=0 (add).
  - 0x2B sw: 0 0 1 1 0 0 op=0.
  - 0x04 beq: 0 0 0 0 0 1 op=1 (sub).
  - 0x08 addi: 1 0 0 1 0 0 op=0.
  - 0x0C andi: 1 0 0 1 0 0 op=3.
  - 0x0D ori: 1 0 0 1 0 0 op=4.
  - 0x0A slti: 1 0 0 1 0 0 op=5.
  - Any other opcode: all controls 0, id_illegal=1, id_valid still 1.
- Register file:
  - Write on rising edge when wb_en && wb_addr != 0. Writes to r0 are ignored; r0 reads 0.
  - Read bypass: if wb_en && wb_addr != 0 && wb_addr == rs (or rt), the operand takes wb_data in the same cycle.
- Hazard:
  - `stall` = IF/ID valid && ex_mem_read && ex_rt != 0 && (ex_rt == rs || (ex_rt == rt && opcode ∈ {R-type, sw, beq})).
  - While stall=1, ID/EX loads a bubble: id_valid=0, all control 0, data fields don't-care but driven 0.
  - Stall lasts exactly while the condition holds. Execute clears ex_mem_read after the bubble, so one cycle is typical.
- Simultaneous load_mem_en and stall: load_mem_en wins for IF/ID (bubble). ID/EX still bubbles.
- Reset asserted mid-stall: everything clears immediately and `stall` drops.
- No forwarding from EX/MEM; that is the execute stage's job.

Decomposition:
- Shared package `mips_pkg`: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI), ALU_OP encodings, field bit positions.
- One sub-module, `register_file`: 2 read ports, 1 write port, r0 hardwired, async reset, internal bypass.
- Decode and hazard logic stay inline.

Test Plan:
- Reset then instr=0x8C020004 (lw $2,4($0)), pc_in=0 → after 2 edges: id_valid=1, mem_read=1, alu_src=1, reg_write=1, id_rt=2, id_imm=0x4.
- wb_en=1, wb_addr=5, wb_data=0xDEADBEEF in the same cycle that add $3,$5,$0 sits in IF/ID → id_rs_data=0xDEADBEEF (bypass). Writing r0 with 0x1234 → later read of $0 returns 0.
- ex_mem_read=1, ex_rt=2, IF/ID holds add $4,$2,$1:
  - stall=1 for one cycle; next ID/EX is a bubble (id_valid=0, reg_write=0).
  - After ex_mem_read drops, the add issues with id_rs=2.
- Same load-use but ex_rt=2 with IF/ID addi $2 used as rt-destination only (addi $2,$1,5) → no stall. With ex_rt=0 → no stall.
- andi $1,$1,0xFFFF → id_imm=0x0000FFFF. addi $1,$1,-1 → id_imm=0xFFFFFFFF. opcode 0x3F → id_illegal=1, all controls 0.
- load_mem_en held 3 cycles → id_valid=0 for those cycles. Assert rst_n=0 mid-stall → stall=0 and all id_* =0 immediately.
